// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl shared types: FSM states and RV32I load/store funct3 codes.
// Also holds the natural-alignment test used by MEM_MISALIGN_TRAP_EN.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic is_misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic r;
    r = 1'b0;
    unique case (1'b1)
      (f3 == F3_H), (f3 == F3_HU): r = off[0];
      (f3 == F3_W):                r = |off;
      default:                     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Data-cache request/response bus between dmem_ctrl and the D-cache.
// master = controller side, slave = cache side.
interface dmem_ctrl_if;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_read, dmem_write, dmem_address,
    output dmem_wdata, dmem_mbe,
    input  dmem_resp, dmem_rdata
  );

  modport slave (
    input  dmem_read, dmem_write, dmem_address,
    input  dmem_wdata, dmem_mbe,
    output dmem_resp, dmem_rdata
  );
endinterface

// File: rtl/dmem_ctrl_mem_align.sv
// mem_align: store byte-lane steering/mask and load extraction/extension.
// Purely combinational; store and load sides have independent controls.
module mem_align
  import dmem_ctrl_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [3:0]  mbe,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [4:0]  st_sh;
  logic [4:0]  ld_sh;
  logic [31:0] word;

  assign st_sh = {st_off, 3'b000};
  assign ld_sh = {ld_off, 3'b000};
  assign word  = ld_word >> ld_sh;

  always_comb begin
    mbe   = 4'b0000;
    wdata = 32'h0;
    unique case (1'b1)
      (st_funct3 == F3_B): begin
        mbe   = 4'b0001 << st_off;
        wdata = st_data << st_sh;
      end
      (st_funct3 == F3_H): begin
        mbe   = 4'b0011 << st_off;
        wdata = st_data << st_sh;
      end
      (st_funct3 == F3_W): begin
        mbe   = 4'b1111;
        wdata = st_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_data = 32'h0;
    unique case (1'b1)
      (ld_funct3 == F3_B):
        ld_data = {{24{word[7]}}, word[7:0]};
      (ld_funct3 == F3_H):
        ld_data = {{16{word[15]}}, word[15:0]};
      (ld_funct3 == F3_W):
        ld_data = word;
      (ld_funct3 == F3_BU):
        ld_data = {24'h0, word[7:0]};
      (ld_funct3 == F3_HU):
        ld_data = {16'h0, word[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: IDLE -> WAIT -> DONE request FSM.
// Optional macro MEM_MISALIGN_TRAP_EN blocks misaligned accesses.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        exmem_valid,
  input  logic        exmem_mem_read,
  input  logic        exmem_mem_write,
  input  logic [2:0]  exmem_funct3,
  input  logic [31:0] exmem_alu_out,
  input  logic [31:0] exmem_rs2_out,
  input  logic        pipe_advance,
  dmem_ctrl_if.master bus,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        mem_misaligned
);

  dmem_state_t state, state_n;

  logic        req_read;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_mbe;
  logic [2:0]  req_funct3;
  logic [1:0]  req_off;
  logic [31:0] hold;

  logic        acc;
  logic        mis;
  logic        go;
  logic [3:0]  al_mbe;
  logic [31:0] al_wdata;
  logic [31:0] ld_data;

  assign acc = exmem_valid
             & (exmem_mem_read | exmem_mem_write);

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = acc & is_misaligned(
    exmem_funct3, exmem_alu_out[1:0]);
`else
  assign mis = 1'b0;
`endif

  assign go = acc & ~mis;
  assign mem_misaligned = mis;

  mem_align u_align (
    .st_funct3 (exmem_funct3),
    .st_off    (exmem_alu_out[1:0]),
    .st_data   (exmem_rs2_out),
    .ld_funct3 (req_funct3),
    .ld_off    (req_off),
    .ld_word   (bus.dmem_rdata),
    .mbe       (al_mbe),
    .wdata     (al_wdata),
    .ld_data   (ld_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n   = state;
    mem_stall = 1'b0;
    unique case (state)
      IDLE: begin
        mem_stall = go;
        if (go) state_n = WAIT;
      end
      WAIT: begin
        mem_stall = 1'b1;
        if (bus.dmem_resp) state_n = DONE;
      end
      DONE: begin
        if (pipe_advance) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Request registers are cleared on response so requests drop in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_read   <= 1'b0;
      req_write  <= 1'b0;
      req_addr   <= 32'h0;
      req_wdata  <= 32'h0;
      req_mbe    <= 4'h0;
      req_funct3 <= 3'h0;
      req_off    <= 2'h0;
      hold       <= 32'h0;
    end else if (state == IDLE && go) begin
      req_read   <= exmem_mem_read;
      req_write  <= exmem_mem_write & ~exmem_mem_read;
      req_addr   <= {exmem_alu_out[31:2], 2'b00};
      req_wdata  <= exmem_mem_read ? 32'h0 : al_wdata;
      req_mbe    <= exmem_mem_read ? 4'h0 : al_mbe;
      req_funct3 <= exmem_funct3;
      req_off    <= exmem_alu_out[1:0];
    end else if (state == WAIT && bus.dmem_resp) begin
      req_read   <= 1'b0;
      req_write  <= 1'b0;
      req_addr   <= 32'h0;
      req_wdata  <= 32'h0;
      req_mbe    <= 4'h0;
      hold       <= req_read ? ld_data : 32'h0;
    end
  end

  assign bus.dmem_read    = req_read;
  assign bus.dmem_write   = req_write;
  assign bus.dmem_address = req_addr;
  assign bus.dmem_wdata   = req_wdata;
  assign bus.dmem_mbe     = req_mbe;

  assign mem_rdata = (state == DONE) ? hold : 32'h0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a load-result scoreboard queue.
// Follows MEM_MISALIGN_TRAP_EN if defined for the build.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        exmem_valid;
  logic        exmem_mem_read;
  logic        exmem_mem_write;
  logic [2:0]  exmem_funct3;
  logic [31:0] exmem_alu_out;
  logic [31:0] exmem_rs2_out;
  logic        pipe_advance;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        mem_misaligned;

  dmem_ctrl_if bus ();

  dmem_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .exmem_valid     (exmem_valid),
    .exmem_mem_read  (exmem_mem_read),
    .exmem_mem_write (exmem_mem_write),
    .exmem_funct3    (exmem_funct3),
    .exmem_alu_out   (exmem_alu_out),
    .exmem_rs2_out   (exmem_rs2_out),
    .pipe_advance    (pipe_advance),
    .bus             (bus),
    .mem_rdata       (mem_rdata),
    .mem_stall       (mem_stall),
    .mem_misaligned  (mem_misaligned)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int req_edges = 0;
  logic req_prev = 1'b0;
  logic [31:0] sb_q[$];

  always @(posedge clk) begin
    if ((bus.dmem_read | bus.dmem_write) && !req_prev)
      req_edges++;
    req_prev = bus.dmem_read | bus.dmem_write;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    exmem_valid     = 1'b0;
    exmem_mem_read  = 1'b0;
    exmem_mem_write = 1'b0;
    exmem_funct3    = 3'b000;
    exmem_alu_out   = 32'h0;
    exmem_rs2_out   = 32'h0;
    pipe_advance    = 1'b0;
  endtask

  task automatic access(
    input string       nm,
    input logic        rd,
    input logic        wr,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] rs2,
    input logic [31:0] rdata,
    input int          dly,
    input int          hold,
    input logic [31:0] exp_addr,
    input logic [3:0]  exp_mbe,
    input logic [31:0] exp_wdata,
    input logic [31:0] exp_rdata
  );
    int stall_n;
    int edges0;
    logic [31:0] want;
    stall_n = 0;
    edges0  = req_edges;
    sb_q.push_back(exp_rdata);
    @(posedge clk); #1;
    exmem_valid     = 1'b1;
    exmem_mem_read  = rd;
    exmem_mem_write = wr;
    exmem_funct3    = f3;
    exmem_alu_out   = addr;
    exmem_rs2_out   = rs2;
    pipe_advance    = 1'b0;
    @(negedge clk);
    if (mem_stall) stall_n++;
    check({nm, " idle_req"},
          {30'h0, bus.dmem_read, bus.dmem_write}, 32'h0);
    @(posedge clk); #1;
    for (int k = 0; k <= dly; k++) begin
      if (k == dly) begin
        bus.dmem_resp  = 1'b1;
        bus.dmem_rdata = rdata;
      end
      @(negedge clk);
      if (mem_stall) stall_n++;
      check({nm, " rd"}, bus.dmem_read, rd);
      check({nm, " wr"}, bus.dmem_write, wr);
      check({nm, " addr"}, bus.dmem_address, exp_addr);
      if (wr) begin
        check({nm, " mbe"}, bus.dmem_mbe, exp_mbe);
        check({nm, " wdata"}, bus.dmem_wdata, exp_wdata);
      end
      @(posedge clk); #1;
      bus.dmem_resp  = 1'b0;
      bus.dmem_rdata = 32'hA5A5_A5A5;
    end
    check({nm, " stall_cycles"}, stall_n, dly + 2);
    want = sb_q.pop_front();
    for (int h = 0; h <= hold; h++) begin
      if (h == 0 && hold > 0) begin
        bus.dmem_resp  = 1'b1;
        bus.dmem_rdata = 32'h5A5A_5A5A;
      end
      if (h == hold) pipe_advance = 1'b1;
      @(negedge clk);
      check({nm, " rdata"}, mem_rdata, want);
      check({nm, " done_stall"}, mem_stall, 1'b0);
      check({nm, " done_req"},
            {30'h0, bus.dmem_read, bus.dmem_write}, 32'h0);
      @(posedge clk); #1;
      bus.dmem_resp = 1'b0;
    end
    idle_inputs();
    check({nm, " one_req"}, req_edges - edges0, 1);
    @(negedge clk);
    check({nm, " idle_rdata"}, mem_rdata, 32'h0);
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    bus.dmem_resp  = 1'b0;
    bus.dmem_rdata = 32'h0;
    #12;
    check("rst rd", bus.dmem_read, 1'b0);
    check("rst wr", bus.dmem_write, 1'b0);
    check("rst addr", bus.dmem_address, 32'h0);
    check("rst mbe", bus.dmem_mbe, 4'h0);
    check("rst rdata", mem_rdata, 32'h0);
    check("rst stall", mem_stall, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;

    access("lw", 1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF,
           0, 0, 32'h100, 0, 0, 32'hDEADBEEF);
    access("lb", 1, 0, 3'b000, 32'h103, 0, 32'h80112233,
           0, 0, 32'h100, 0, 0, 32'hFFFFFF80);
    access("lbu", 1, 0, 3'b100, 32'h103, 0, 32'h80112233,
           0, 0, 32'h100, 0, 0, 32'h00000080);
    access("lh", 1, 0, 3'b001, 32'h102, 0, 32'h80011234,
           1, 0, 32'h100, 0, 0, 32'hFFFF8001);
    access("lhu", 1, 0, 3'b101, 32'h102, 0, 32'h80011234,
           0, 1, 32'h100, 0, 0, 32'h00008001);
    access("sh", 0, 1, 3'b001, 32'h202, 32'h0000ABCD, 0,
           0, 0, 32'h200, 4'b1100, 32'hABCD0000, 0);
    access("sb", 0, 1, 3'b000, 32'h101, 32'h12345678, 0,
           2, 0, 32'h100, 4'b0010, 32'h34567800, 0);
    access("sw", 0, 1, 3'b010, 32'h300, 32'hCAFEF00D, 0,
           0, 0, 32'h300, 4'b1111, 32'hCAFEF00D, 0);
    access("lw_slow", 1, 0, 3'b010, 32'h104, 0,
           32'h13572468, 5, 3, 32'h104, 0, 0, 32'h13572468);

    @(posedge clk); #1;
    exmem_valid  = 1'b1;
    exmem_alu_out = 32'h500;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("nonmem stall", mem_stall, 1'b0);
      check("nonmem rd", bus.dmem_read, 1'b0);
    end
    idle_inputs();

    @(posedge clk); #1;
    exmem_valid    = 1'b1;
    exmem_mem_read = 1'b1;
    exmem_funct3   = 3'b010;
    exmem_alu_out  = 32'h400;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstw rd_before", bus.dmem_read, 1'b1);
    #2;
    rst = 1'b0;
    idle_inputs();
    #1;
    check("rstw rd_drop", bus.dmem_read, 1'b0);
    check("rstw stall", mem_stall, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    bus.dmem_resp  = 1'b1;
    bus.dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("stale rdata", mem_rdata, 32'h0);
    check("stale stall", mem_stall, 1'b0);
    @(posedge clk); #1;
    bus.dmem_resp = 1'b0;
    @(negedge clk);
    check("stale rdata2", mem_rdata, 32'h0);
    check("stale rd", bus.dmem_read, 1'b0);

    access("lw_post", 1, 0, 3'b010, 32'h108, 0,
           32'h0BADF00D, 0, 0, 32'h108, 0, 0, 32'h0BADF00D);

`ifdef MEM_MISALIGN_TRAP_EN
    @(posedge clk); #1;
    exmem_valid    = 1'b1;
    exmem_mem_read = 1'b1;
    exmem_funct3   = 3'b010;
    exmem_alu_out  = 32'h101;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mis rd", bus.dmem_read, 1'b0);
      check("mis stall", mem_stall, 1'b0);
      check("mis flag", mem_misaligned, 1'b1);
      check("mis rdata", mem_rdata, 32'h0);
    end
    idle_inputs();
    @(negedge clk);
    check("mis flag_clr", mem_misaligned, 1'b0);
`else
    access("lw_mis", 1, 0, 3'b010, 32'h101, 0,
           32'h11223344, 0, 0, 32'h100, 0, 0, 32'h00112233);
    check("mis flag_off", mem_misaligned, 1'b0);
`endif

    check("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

MEM-stage data-memory controller for the RV32I pipeline, sitting between the EX/MEM register and the MEM/WB register. It turns a load/store in EX/MEM into a registered request to the data cache, stalls the pipeline until the cache responds, and holds the aligned, extended load data stable until MEM/WB captures it. Stores get byte-lane alignment and a byte-enable mask.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- exmem_valid  in  1  EX/MEM holds a live instruction
- exmem_mem_read  in  1  instruction is a load
- exmem_mem_write  in  1  instruction is a store
- exmem_funct3  in  3  load/store width code
- exmem_alu_out  in  32  effective byte address
- exmem_rs2_out  in  32  store data, unaligned
- pipe_advance  in  1  MEM/WB load strobe for this cycle
- dmem_read  out  1  cache read request
- dmem_write  out  1  cache write request
- dmem_address  out  32  word address, bits [1:0] = 0
- dmem_wdata  out  32  lane-aligned store data
- dmem_mbe  out  4  byte enables
- dmem_resp  in  1  cache completion, one-cycle pulse
- dmem_rdata  in  32  cache read word, valid with dmem_resp
- mem_rdata  out  32  extended load result to MEM/WB
- mem_stall  out  1  freeze IF..EX/MEM, and MEM/WB load
- mem_misaligned  out  1  misaligned access flag (MEM_MISALIGN_TRAP_EN only)

## Operation
- Access condition: acc = exmem_valid & (exmem_mem_read | exmem_mem_write).
- FSM states:
  - IDLE: if acc, latch the op, word address, aligned wdata and mbe into request registers, then go to WAIT. mem_stall = acc.
  - WAIT: drive dmem_read or dmem_write from the request registers. mem_stall = 1. On dmem_resp, capture the extended data into the hold register and go to DONE.
  - DONE: requests low. mem_stall = 0. mem_rdata = hold register. On pipe_advance, go to IDLE.
- Store alignment, off = addr[1:0]:
  - SB (000): mbe = 0001<<off, wdata = rs2<<(8*off).
  - SH (001): mbe = 0011<<off, truncated to 4 bits.
  - SW (010): mbe = 1111.
- Load extension: word = dmem_rdata>>(8*off).
  - LB: sign-extend word[7:0].
  - LH: sign-extend word[15:0].
  - LW: word.
  - LBU / LHU: zero-extend the same fields.
- Stores complete with the hold register = 0.
- mem_rdata = 0 in IDLE and WAIT.
- Reset values: state IDLE; all request registers, the hold register and every output = 0.

## Timing
- Request is registered, so it appears the cycle after the instruction enters EX/MEM.
- Minimum access latency is 3 cycles (IDLE, WAIT with same-cycle dmem_resp, DONE). The stall lasts 2 cycles.
- Requests stay asserted and stable in WAIT until dmem_resp.
- dmem_resp outside WAIT is ignored.
- DONE with pipe_advance low (another stall source) holds mem_rdata and issues no new request.
- Non-memory instructions never leave IDLE and never stall.
- Reset asserted mid-WAIT drops requests immediately. A cache response arriving after reset is ignored.
- pipe_advance in IDLE or WAIT has no effect on state.

## Configuration
- MEM_MISALIGN_TRAP_EN:
  - Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, issue no request. FSM stays IDLE, mem_stall=0, mem_rdata=0, and mem_misaligned=1 combinationally while that instruction sits in EX/MEM.
  - Undefined: misaligned accesses follow the truncation rules above, and mem_misaligned is tied to 0.

## Structure
- Shared package: dmem_state_t enum (IDLE/WAIT/DONE) and load/store funct3 encodings, reusing the rv32i_types encodings where present.
- Sub-module mem_align: combinational. Produces mbe, aligned wdata and extended load data from funct3, offset and the raw words. FSM and registers live in dmem_ctrl.

## Test plan
- LW at 0x100, dmem_rdata=0xDEADBEEF, resp in the first WAIT cycle -> dmem_address=0x100, mem_stall high 2 cycles, mem_rdata=0xDEADBEEF in DONE.
- LB at 0x103, rdata=0x80112233 -> mem_rdata=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH at 0x202, rs2=0x0000ABCD -> dmem_address=0x200, mbe=1100, wdata=0xABCD0000.
- Load with dmem_resp delayed 5 cycles, then pipe_advance held low 3 cycles in DONE -> request stable, mem_rdata stable, exactly one request issued.
- rst driven low during WAIT -> dmem_read=0 immediately. After release, a stale dmem_resp is ignored and the FSM stays IDLE.
- MEM_MISALIGN_TRAP_EN defined, LW at 0x101 -> no dmem_read, mem_stall=0, mem_misaligned=1. Undefined -> read issued to 0x100.
